// File: rtl/sdp_ram_be_clr_pkg.sv
// Shared definitions for the byte-enable SDP RAM with clear sequencer:
// read-during-write modes, clear FSM encoding and lane-count helper.
`timescale 1ns/1ps
package sdp_ram_be_clr_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  function automatic int num_bytes(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

endpackage

// File: rtl/sdp_ram_be_clr_if.sv
// User-side bus of the SDP RAM: write port with lane enables, qualified read
// port and clear request, plus read data/valid and clear-busy status.
`timescale 1ns/1ps
interface sdp_ram_be_clr_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int BYTE_WIDTH = 8
);
  import sdp_ram_be_clr_pkg::*;

  localparam int NUM_BYTES = num_bytes(DATA_WIDTH, BYTE_WIDTH);

  logic                  Write_enable_i;
  logic [NUM_BYTES-1:0]  Byte_enable__i;
  logic [ADDR_WIDTH-1:0] Write_addres_i;
  logic [DATA_WIDTH-1:0] data_input___i;
  logic                  Read_enable__i;
  logic [ADDR_WIDTH-1:0] Read_address_i;
  logic                  Clear_start__i;
  logic [DATA_WIDTH-1:0] data_output__o;
  logic                  Read_valid___o;
  logic                  Clear_busy___o;

  modport master (
    output Write_enable_i, Byte_enable__i, Write_addres_i, data_input___i,
    output Read_enable__i, Read_address_i, Clear_start__i,
    input  data_output__o, Read_valid___o, Clear_busy___o
  );

  modport slave (
    input  Write_enable_i, Byte_enable__i, Write_addres_i, data_input___i,
    input  Read_enable__i, Read_address_i, Clear_start__i,
    output data_output__o, Read_valid___o, Clear_busy___o
  );

endinterface

// File: rtl/sdp_ram_clear_seq.sv
// Clear sequencer: walks every address once after reset or on request,
// strobing a full-word write of the clear value at each step.
`timescale 1ns/1ps
module sdp_ram_clear_seq
  import sdp_ram_be_clr_pkg::*;
#(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_start,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  clr_we
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A start request while already clearing is ignored; the walk never restarts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy     = (state_q == ST_CLEAR);
  assign clr_addr = cnt_q;
  assign clr_we   = (state_q == ST_CLEAR) && !rst;

endmodule

// File: rtl/sdp_ram_be_clr.sv
// Single-clock simple dual-port RAM with byte-lane writes, read valid strobe,
// selectable read-during-write, optional output register and hardware clear.
`timescale 1ns/1ps
module sdp_ram_be_clr
  import sdp_ram_be_clr_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 6,
  parameter int                    BYTE_WIDTH  = 8,
  parameter int                    OUTPUT_REG  = 0,
  parameter int                    RDW_MODE    = 0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic             Clock________i,
  input  logic             Reset________i,
  sdp_ram_be_clr_if.slave  bus
);

  localparam int NUM_BYTES = num_bytes(DATA_WIDTH, BYTE_WIDTH);
  localparam int DEPTH     = 1 << ADDR_WIDTH;

  if ((DATA_WIDTH % BYTE_WIDTH) != 0 || (OUTPUT_REG != 0 && OUTPUT_REG != 1) ||
      (RDW_MODE != RDW_OLD && RDW_MODE != RDW_NEW)) begin : g_param_err
    $error("sdp_ram_be_clr: illegal DATA_WIDTH/BYTE_WIDTH, OUTPUT_REG or RDW_MODE");
  end

  logic                  busy, clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  sdp_ram_clear_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_clear_seq (
    .clk         (Clock________i),
    .rst         (Reset________i),
    .clear_start (bus.Clear_start__i),
    .busy        (busy),
    .clr_addr    (clr_addr),
    .clr_we      (clr_we)
  );

  logic [DATA_WIDTH-1:0] mem_array [DEPTH];
  logic                  wr_en;
  logic [NUM_BYTES-1:0]  wr_be;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  // The clear sequencer owns the write port while busy; user writes are dropped.
  always_comb begin
    wr_en   = 1'b0;
    wr_be   = '0;
    wr_addr = bus.Write_addres_i;
    wr_data = bus.data_input___i;
    if (clr_we) begin
      wr_en   = 1'b1;
      wr_be   = '1;
      wr_addr = clr_addr;
      wr_data = CLEAR_VALUE;
    end else if (bus.Write_enable_i && !busy && !Reset________i) begin
      wr_en = 1'b1;
      wr_be = bus.Byte_enable__i;
    end
  end

  always_ff @(posedge Clock________i) begin
    if (wr_en) begin
      for (int k = 0; k < NUM_BYTES; k++) begin
        if (wr_be[k]) mem_array[wr_addr][k*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[k*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Stage 1: read capture, with same-address write merge in RDW_NEW mode
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_word, rd_merged, rd_fwd;
  logic [DATA_WIDTH-1:0] rd_data_p1_q, rd_data_p1_d;
  logic                  vld_p1_q, vld_p1_d;

  always_comb begin
    rd_en     = bus.Read_enable__i && !busy && !Reset________i;
    rd_word   = mem_array[bus.Read_address_i];
    rd_merged = rd_word;
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (wr_en && wr_be[k]) rd_merged[k*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[k*BYTE_WIDTH +: BYTE_WIDTH];
    end
    rd_fwd = (RDW_MODE == RDW_NEW && wr_en && wr_addr == bus.Read_address_i) ? rd_merged : rd_word;
    rd_data_p1_d = rd_en ? rd_fwd : rd_data_p1_q;
    vld_p1_d     = rd_en;
  end

  always_ff @(posedge Clock________i) begin
    if (Reset________i) begin
      rd_data_p1_q <= '0;
      vld_p1_q     <= 1'b0;
    end else begin
      rd_data_p1_q <= rd_data_p1_d;
      vld_p1_q     <= vld_p1_d;
    end
  end

  // Stage 2: optional output register, loads only on a valid stage-1 word
  if (OUTPUT_REG == 1) begin : g_out_reg
    logic [DATA_WIDTH-1:0] rd_data_p2_q, rd_data_p2_d;
    logic                  vld_p2_q, vld_p2_d;

    always_comb begin
      rd_data_p2_d = vld_p1_q ? rd_data_p1_q : rd_data_p2_q;
      vld_p2_d     = vld_p1_q;
    end

    always_ff @(posedge Clock________i) begin
      if (Reset________i) begin
        rd_data_p2_q <= '0;
        vld_p2_q     <= 1'b0;
      end else begin
        rd_data_p2_q <= rd_data_p2_d;
        vld_p2_q     <= vld_p2_d;
      end
    end

    assign bus.data_output__o = rd_data_p2_q;
    assign bus.Read_valid___o = vld_p2_q;
  end else begin : g_no_out_reg
    assign bus.data_output__o = rd_data_p1_q;
    assign bus.Read_valid___o = vld_p1_q;
  end

  assign bus.Clear_busy___o = busy;

endmodule

// File: tb/tb_sdp_ram_be_clr.sv
// Scoreboard bench: two instances (latency 1 / old-data RDW, latency 2 /
// new-data RDW) driven with identical directed vectors.
`timescale 1ns/1ps
module tb_sdp_ram_be_clr;
  import sdp_ram_be_clr_pkg::*;

  localparam logic [31:0] CV = 32'hA5A5A5A5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, we, re, cs;
  logic [3:0]  be;
  logic [5:0]  waddr, raddr;
  logic [31:0] wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t q0[$], q1[$];
  exp_t e0, e1;
  logic [31:0] last0 = '0, last1 = '0;

  sdp_ram_be_clr_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .BYTE_WIDTH(8)) if0 ();
  sdp_ram_be_clr_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .BYTE_WIDTH(8)) if1 ();

  assign if0.Write_enable_i = we;    assign if1.Write_enable_i = we;
  assign if0.Byte_enable__i = be;    assign if1.Byte_enable__i = be;
  assign if0.Write_addres_i = waddr; assign if1.Write_addres_i = waddr;
  assign if0.data_input___i = wdata; assign if1.data_input___i = wdata;
  assign if0.Read_enable__i = re;    assign if1.Read_enable__i = re;
  assign if0.Read_address_i = raddr; assign if1.Read_address_i = raddr;
  assign if0.Clear_start__i = cs;    assign if1.Clear_start__i = cs;

  sdp_ram_be_clr #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .BYTE_WIDTH(8), .OUTPUT_REG(0),
                   .RDW_MODE(0), .CLEAR_VALUE(CV)) dut0 (
    .Clock________i (clk),
    .Reset________i (rst),
    .bus            (if0)
  );

  sdp_ram_be_clr #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .BYTE_WIDTH(8), .OUTPUT_REG(1),
                   .RDW_MODE(1), .CLEAR_VALUE(CV)) dut1 (
    .Clock________i (clk),
    .Reset________i (rst),
    .bus            (if1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  // Monitors: every valid strobe must match the oldest expected read, on its cycle.
  always @(negedge clk) begin
    if (if0.Read_valid___o) begin
      if (q0.size() == 0) chk("dut0 unexpected valid", {31'b0, if0.Read_valid___o}, 32'd0);
      else begin
        e0 = q0.pop_front();
        chk("dut0 rdata", if0.data_output__o, e0.data);
        chk("dut0 rcycle", cyc, e0.cyc);
        last0 = e0.data;
      end
    end
  end

  always @(negedge clk) begin
    if (if1.Read_valid___o) begin
      if (q1.size() == 0) chk("dut1 unexpected valid", {31'b0, if1.Read_valid___o}, 32'd0);
      else begin
        e1 = q1.pop_front();
        chk("dut1 rdata", if1.data_output__o, e1.data);
        chk("dut1 rcycle", cyc, e1.cyc);
        last1 = e1.data;
      end
    end
  end

  // Called at #1 after a rising edge; returns at #1 after the next one.
  task automatic drive(input logic we_i, input logic [3:0] be_i, input logic [5:0] wa,
                       input logic [31:0] wd, input logic re_i, input logic [5:0] ra,
                       input logic [31:0] x0, input logic [31:0] x1);
    we = we_i; be = be_i; waddr = wa; wdata = wd; re = re_i; raddr = ra;
    if (re_i) begin
      q0.push_back('{data: x0, cyc: cyc + 1});
      q1.push_back('{data: x1, cyc: cyc + 2});
    end
    @(posedge clk); #1;
    we = 1'b0; re = 1'b0;
  endtask

  task automatic rd(input logic [5:0] ra, input logic [31:0] x);
    drive(1'b0, 4'h0, 6'd0, 32'd0, 1'b1, ra, x, x);
  endtask

  task automatic wr(input logic [3:0] be_i, input logic [5:0] wa, input logic [31:0] wd);
    drive(1'b1, be_i, wa, wd, 1'b0, 6'd0, 32'd0, 32'd0);
  endtask

  // Counts busy cycles; mid-clear it attempts a write+read of addr 3 and a
  // second clear request, all of which must be dropped.
  task automatic count_busy(input string name);
    int n0 = 0, n1 = 0, it = 0;
    @(negedge clk);
    while ((if0.Clear_busy___o || if1.Clear_busy___o) && it < 200) begin
      if (if0.Clear_busy___o) n0++;
      if (if1.Clear_busy___o) n1++;
      we = (it == 5); re = (it == 5); cs = (it == 30);
      be = 4'hF; waddr = 6'd3; raddr = 6'd3; wdata = 32'hDEADBEEF;
      it++;
      @(negedge clk);
    end
    we = 1'b0; re = 1'b0; cs = 1'b0;
    chk({name, " dut0 cycles"}, n0, 32'd64);
    chk({name, " dut1 cycles"}, n1, 32'd64);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; cs = 1'b0;
    be = '0; waddr = '0; raddr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset dut0 data", if0.data_output__o, 32'd0);
    chk("reset dut0 valid", {31'b0, if0.Read_valid___o}, 32'd0);
    chk("reset dut0 busy", {31'b0, if0.Clear_busy___o}, 32'd1);
    chk("reset dut1 data", if1.data_output__o, 32'd0);
    chk("reset dut1 valid", {31'b0, if1.Read_valid___o}, 32'd0);
    chk("reset dut1 busy", {31'b0, if1.Clear_busy___o}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    count_busy("clear after reset");

    for (int i = 0; i < 64; i++) rd(6'(i), CV);

    wr(4'hF, 6'd5, 32'h11223344);
    wr(4'b0101, 6'd5, 32'hAABBCCDD);
    rd(6'd5, 32'h11BB33DD);
    wr(4'h0, 6'd5, 32'h00000000);
    rd(6'd5, 32'h11BB33DD);

    wr(4'hF, 6'd9, 32'h00000000);
    drive(1'b1, 4'hF, 6'd9, 32'hFFFFFFFF, 1'b1, 6'd9, 32'h00000000, 32'hFFFFFFFF);
    rd(6'd9, 32'hFFFFFFFF);
    wr(4'hF, 6'd10, 32'h12345678);
    drive(1'b1, 4'b0011, 6'd10, 32'hAABBCCDD, 1'b1, 6'd10, 32'h12345678, 32'h1234CCDD);
    drive(1'b1, 4'hF, 6'd11, 32'hCAFEF00D, 1'b1, 6'd10, 32'h1234CCDD, 32'h1234CCDD);
    rd(6'd11, 32'hCAFEF00D);

    wr(4'hF, 6'd1, 32'h01010101);
    wr(4'hF, 6'd2, 32'h02020202);
    wr(4'hF, 6'd3, 32'h03030303);
    rd(6'd1, 32'h01010101);
    rd(6'd2, 32'h02020202);
    rd(6'd3, 32'h03030303);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("dut0 hold data", if0.data_output__o, last0);
    chk("dut1 hold data", if1.data_output__o, last1);
    chk("dut1 hold value", if1.data_output__o, 32'h03030303);
    @(posedge clk); #1;

    cs = 1'b1;
    wr(4'hF, 6'd7, 32'h77777777);
    cs = 1'b0;
    count_busy("clear on request");
    rd(6'd7, CV);
    rd(6'd3, CV);
    rd(6'd5, CV);

    cs = 1'b1;
    @(posedge clk); #1;
    cs = 1'b0;
    for (int i = 0; i < 20; i++) begin
      we = (i == 2); re = (i == 2); be = 4'hF;
      waddr = 6'd40; raddr = 6'd40; wdata = 32'h40404040;
      @(posedge clk); #1;
    end
    we = 1'b0; re = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid-clear reset dut0 busy", {31'b0, if0.Clear_busy___o}, 32'd1);
    chk("mid-clear reset dut1 valid", {31'b0, if1.Read_valid___o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    count_busy("clear after mid-clear reset");
    rd(6'd40, CV);
    rd(6'd9, CV);
    rd(6'd63, CV);

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("dut0 pending reads", q0.size(), 32'd0);
    chk("dut1 pending reads", q1.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
